// File: rtl/bounce_sprite_engine_if.sv
// Port bundle for the bouncing-sprite renderer: frame/speed control,
// pixel coordinates in, registered colour and event status out.
interface bounce_sprite_engine_if #(
    parameter int NUM_SPRITES = 4
);
    logic                       frame_tick;
    logic                       pause;
    logic [8*NUM_SPRITES-1:0]   speed;
    logic [9:0]                 pix_x;
    logic [9:0]                 pix_y;
    logic                       video_active;
    logic [5:0]                 rgb;
    logic                       busy;
    logic                       bounce_pulse;
    logic                       corner_pulse;
    logic [15:0]                bounce_count;
    logic                       overlap_seen;

    modport master (
        output frame_tick, pause, speed,
        output pix_x, pix_y, video_active,
        input  rgb, busy, bounce_pulse,
        input  corner_pulse, bounce_count, overlap_seen
    );

    modport slave (
        input  frame_tick, pause, speed,
        input  pix_x, pix_y, video_active,
        output rgb, busy, bounce_pulse,
        output corner_pulse, bounce_count, overlap_seen
    );
endinterface

// File: rtl/bounce_sprite_engine.sv
// Moves NUM_SPRITES squares once per frame (one sprite per cycle) and
// renders them inside a white border onto a registered 6-bit pixel.
module bounce_sprite_engine #(
    parameter int NUM_SPRITES  = 4,
    parameter int SPRITE_SIZE  = 50,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BORDER_WIDTH = 2,
    parameter logic [6*NUM_SPRITES-1:0] SPRITE_RGB = 24'hC03324
) (
    input  logic clk,
    input  logic rst_n,
    bounce_sprite_engine_if.slave bus
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [10:0] SZ = 11'(SPRITE_SIZE);
    localparam logic [10:0] HR = 11'(H_RES);
    localparam logic [10:0] VR = 11'(V_RES);
    localparam logic [9:0]  BW = 10'(BORDER_WIDTH);
    localparam logic [9:0]  HB = 10'(H_RES - BORDER_WIDTH);
    localparam logic [9:0]  VB = 10'(V_RES - BORDER_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [9:0]    x_q [NUM_SPRITES];
    logic [9:0]    x_d [NUM_SPRITES];
    logic [9:0]    y_q [NUM_SPRITES];
    logic [9:0]    y_d [NUM_SPRITES];
    logic          hdir_q [NUM_SPRITES];
    logic          hdir_d [NUM_SPRITES];
    logic          vdir_q [NUM_SPRITES];
    logic          vdir_d [NUM_SPRITES];
    logic          bounce_q, bounce_d;
    logic          corner_q, corner_d;
    logic [15:0]   bounce_count_q, bounce_count_d;
    logic [5:0]    rgb_q, rgb_d;
    logic          flag_q, flag_d;
    logic          seen_q, seen_d;

    logic [10:0]   hstep, vstep;
    logic          hrev, vrev;
    logic [NUM_SPRITES-1:0] hit;
    logic          any_hit, multi_hit, in_border;

    // Returns {dir, pos}; dir=1 means right/down. A blocked move
    // flips the direction and leaves the position where it is.
    function automatic logic [10:0] step(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [3:0]  spd,
        input logic [10:0] lim
    );
        logic [10:0] res;
        res = {dir, pos};
        if (spd != 4'd0) begin
            if (dir) begin
                if ({1'b0, pos} + SZ + {7'd0, spd} <= lim)
                    res = {dir, pos + {6'd0, spd}};
                else
                    res = {1'b0, pos};
            end else begin
                if (pos >= {6'd0, spd})
                    res = {dir, pos - {6'd0, spd}};
                else
                    res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        x_d            = x_q;
        y_d            = y_q;
        hdir_d         = hdir_q;
        vdir_d         = vdir_q;
        bounce_d       = 1'b0;
        corner_d       = 1'b0;
        bounce_count_d = bounce_count_q;
        hstep          = '0;
        vstep          = '0;
        hrev           = 1'b0;
        vrev           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_tick && !bus.pause) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (idx_q == IW'(i)) begin
                        hstep = step(x_q[i], hdir_q[i],
                                     bus.speed[8*i+4 +: 4], HR);
                        vstep = step(y_q[i], vdir_q[i],
                                     bus.speed[8*i +: 4], VR);
                        x_d[i]    = hstep[9:0];
                        y_d[i]    = vstep[9:0];
                        hdir_d[i] = hstep[10];
                        vdir_d[i] = vstep[10];
                        hrev      = hstep[10] != hdir_q[i];
                        vrev      = vstep[10] != vdir_q[i];
                    end
                end
                bounce_d = hrev | vrev;
                corner_d = hrev & vrev;
                if (bounce_d && bounce_count_q != 16'hFFFF)
                    bounce_count_d = bounce_count_q + 16'd1;
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit       = '0;
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        rgb_d     = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = ({1'b0, bus.pix_x} >= {1'b0, x_q[i]})
                  && ({1'b0, bus.pix_x} < {1'b0, x_q[i]} + SZ)
                  && ({1'b0, bus.pix_y} >= {1'b0, y_q[i]})
                  && ({1'b0, bus.pix_y} < {1'b0, y_q[i]} + SZ);
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            multi_hit = multi_hit | (any_hit & hit[i]);
            any_hit   = any_hit | hit[i];
        end
        in_border = (bus.pix_x < BW) || (bus.pix_x >= HB)
                 || (bus.pix_y < BW) || (bus.pix_y >= VB);
        // Descending walk so the lowest-index hit wins.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i])
                rgb_d = SPRITE_RGB[6*i +: 6];
        end
        if (in_border)
            rgb_d = 6'h3F;
        if (!bus.video_active)
            rgb_d = '0;
        flag_d = flag_q | (multi_hit & bus.video_active);
        seen_d = seen_q;
        if (bus.frame_tick) begin
            seen_d = flag_q;
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            bounce_q       <= 1'b0;
            corner_q       <= 1'b0;
            bounce_count_q <= '0;
            rgb_q          <= '0;
            flag_q         <= 1'b0;
            seen_q         <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]    <= 10'(i * SPRITE_SIZE);
                y_q[i]    <= '0;
                hdir_q[i] <= 1'b1;
                vdir_q[i] <= 1'b1;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            bounce_q       <= bounce_d;
            corner_q       <= corner_d;
            bounce_count_q <= bounce_count_d;
            rgb_q          <= rgb_d;
            flag_q         <= flag_d;
            seen_q         <= seen_d;
            x_q            <= x_d;
            y_q            <= y_d;
            hdir_q         <= hdir_d;
            vdir_q         <= vdir_d;
        end
    end

    assign bus.rgb          = rgb_q;
    assign bus.busy         = (state_q == UPDATE);
    assign bus.bounce_pulse = bounce_q;
    assign bus.corner_pulse = corner_q;
    assign bus.bounce_count = bounce_count_q;
    assign bus.overlap_seen = seen_q;
endmodule

// File: doc/bounce_sprite_engine.md
Name: bounce_sprite_engine

Overview:
- Multi-sprite bouncing-square renderer for the 640x480 VGA demo path.
- Sits between hvsync_generator (pix_x, pix_y, video_active) and the TinyVGA PMOD colour bits.
- Generalises the single bouncing square: parametrised sprite count, size, resolution and border. Runs on the pixel clock with a frame_tick strobe instead of clocking on vsync.
- Adds per-sprite colour, a registered pixel output, an update FSM, bounce/corner event pulses, a saturating bounce counter and a sprite-overlap flag.

Parameters:
- NUM_SPRITES, 4, number of sprites (1..8); NUM_SPRITES*SPRITE_SIZE <= H_RES.
- SPRITE_SIZE, 50, sprite edge length in pixels.
- H_RES, 640, active width.
- V_RES, 480, active height.
- BORDER_WIDTH, 2, white frame width in pixels.
- SPRITE_RGB, 24'hC03324, packed 6-bit colour per sprite; sprite i uses [6i+5:6i] as {R[1:0],G[1:0],B[1:0]}.

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  reset; asynchronous, active-low.
- frame_tick  input  1  one-cycle strobe, once per frame, issued in vertical blanking.
- pause  input  1  when high at frame_tick, positions are frozen for that frame.
- speed  input  8*NUM_SPRITES  per sprite i: [8i+7:8i+4] = horizontal speed, [8i+3:8i] = vertical speed.
- pix_x  input  10  current pixel column.
- pix_y  input  10  current pixel row.
- video_active  input  1  display-enable from the sync generator.
- rgb  output  6  {R[1:0],G[1:0],B[1:0]}, registered.
- busy  output  1  high while the update FSM is in UPDATE.
- bounce_pulse  output  1  one-cycle pulse when the sprite being updated reverses on either axis.
- corner_pulse  output  1  one-cycle pulse when that sprite reverses on both axes in the same update.
- bounce_count  output  16  count of sprite-updates with any reversal; saturates at 16'hFFFF.
- overlap_seen  output  1  high if two sprites covered the same active pixel during the previous frame.

Behaviour:
- Reset (async, rst_n low):
  - sprite i: x = i*SPRITE_SIZE, y = 0, horizontal dir = right, vertical dir = down.
  - FSM = IDLE.
  - rgb = 0, busy = 0, bounce_pulse = 0, corner_pulse = 0, bounce_count = 0, overlap_seen = 0.
  - Reset mid-UPDATE aborts the update and restores all of the above.
- FSM states: IDLE, UPDATE.
  - IDLE -> UPDATE on frame_tick && !pause; sprite index idx = 0.
  - UPDATE processes sprite idx in one cycle, then increments idx.
  - UPDATE -> IDLE after idx = NUM_SPRITES-1. busy is high for exactly NUM_SPRITES cycles.
  - frame_tick while busy is ignored. frame_tick with pause high leaves all state unchanged.
- Per-axis update (shown for x; y is identical with V_RES). Widths: 10-bit positions, 4-bit speeds, compares at 11 bits so nothing overflows.
  - speed 0: no motion, no reversal.
  - Right: if x+SPRITE_SIZE+hs <= H_RES then x += hs; else dir = left and x is unchanged.
  - Left: if x >= hs then x -= hs; else dir = right and x is unchanged.
- Event outputs, asserted in the cycle following the sprite's update cycle:
  - bounce_pulse = either axis reversed.
  - corner_pulse = both axes reversed.
  - bounce_count +1 per sprite-update with any reversal; holds at FFFF.
- Pixel path, one-cycle latency: rgb at cycle n+1 reflects pix_x, pix_y, video_active at cycle n.
  - in_border: pix_x < BORDER_WIDTH, pix_x >= H_RES-BORDER_WIDTH, pix_y < BORDER_WIDTH, or pix_y >= V_RES-BORDER_WIDTH.
  - in_sprite[i]: x_i <= pix_x < x_i+SPRITE_SIZE and y_i <= pix_y < y_i+SPRITE_SIZE.
  - Priority: !video_active -> 0; in_border -> 6'b111111; else the lowest-index hit sprite's SPRITE_RGB; else 0.
- Overlap flag:
  - A frame-internal flag is set when >= 2 in_sprite bits are high with video_active high.
  - On frame_tick (paused or not), overlap_seen takes the flag value and the flag clears.

Test Plan:
- Reset, NUM_SPRITES=4 -> sprite positions (0,0),(50,0),(100,0),(150,0); all outputs 0; first rgb at pixel (0,0) active = 6'b111111 (border).
- Sprite0 speed 8'h43 at x=586,y=0, two frame_ticks -> x=590,y=3, then x=590 with dir left, y=6; one bounce_pulse; bounce_count=1; busy high 4 cycles per tick.
- Sprite0 x=590,y=427, speed 8'h44, right/down -> both reverse; corner_pulse=1, bounce_pulse=1 for one cycle; position unchanged.
- pause=1 with frame_ticks -> positions, dirs and bounce_count unchanged. frame_tick pulsed during busy -> no second update.
- Sprites 0 and 1 overlapped at (100,100), pixel (120,120) active -> rgb=6'b100100 one cycle later; overlap_seen=1 after next frame_tick; video_active=0 -> rgb=0.
- Force 65535 reversals (or preload bounce_count) then one more bounce -> bounce_count stays 16'hFFFF; rst_n low mid-UPDATE -> busy=0 and reset positions immediately.
